// File: rtl/l8_mod_pkg.sv
// Shared constants and helpers for the mod-255 (end-around carry) arithmetic blocks.
package l8_mod_pkg;

    localparam int W   = 8;
    localparam int MOD = 255;

    typedef logic [W-1:0] word_t;

    // Cyclic rotate-left: bit i of the result is bit (i-k) mod W of v.
    function automatic word_t rotl(input word_t v, input int k);
        return (v << k) | (v >> (W - k));
    endfunction

endpackage

// File: rtl/l8_ling_prefix_lvl.sv
// One combinational level of the cyclic Ling prefix tree: merges each group with the
// group K positions below it, wrapping around so the top carry feeds back into bit 0.
module l8_ling_prefix_lvl
    import l8_mod_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [W-1:0] h,
    input  logic [W-1:0] pr,
    output logic [W-1:0] h_nxt,
    output logic [W-1:0] pr_nxt
);

    assign h_nxt  = h | (pr & rotl(h, K));
    assign pr_nxt = pr & rotl(pr, K);

endmodule

// File: rtl/l8_mod_sub_pipe.sv
// Three-stage mod-255 subtractor: diff = a + ~b with end-around carry, computed by a
// cyclic Ling prefix tree, with valid/ready flow control and optional zero normalisation.
module l8_mod_sub_pipe
    import l8_mod_pkg::*;
#(
    parameter bit NORM_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] diff,
    output logic         out_valid,
    input  logic         out_ready
);

    // Both 8'h00 and 8'hFF encode zero; the adder yields 8'h00 only for 0 + 0.
    function automatic logic [W-1:0] norm_zero(input logic [W-1:0] s);
        if (s == '0 || s == '1)
            return NORM_ZERO ? '0 : '1;
        return s;
    endfunction

    logic         ld_p0, ld_p1, ld_p2;
    logic         vld_p0, vld_p1, vld_p2;
    logic [W-1:0] g_p0, p_p0, x_p0;
    logic [W-1:0] h_lv1, pr_lv1, h_lv2, pr_lv2, h_lv3, pr_unused_lv3;
    logic [W-1:0] h2_p1, pr2_p1, p_p1, x_p1;
    logic [W-1:0] carry, sum;
    logic [W-1:0] diff_p2;

    assign ld_p2    = !vld_p2 || out_ready;
    assign ld_p1    = !vld_p1 || ld_p2;
    assign ld_p0    = !vld_p0 || ld_p1;
    assign in_ready = ld_p0;

    // Ling base: H = g, Pr_i = p_(i-1) (cyclically).
    l8_ling_prefix_lvl #(.K(1)) u_lvl1 (
        .h      (g_p0),
        .pr     (rotl(p_p0, 1)),
        .h_nxt  (h_lv1),
        .pr_nxt (pr_lv1)
    );

    l8_ling_prefix_lvl #(.K(2)) u_lvl2 (
        .h      (h_lv1),
        .pr     (pr_lv1),
        .h_nxt  (h_lv2),
        .pr_nxt (pr_lv2)
    );

    l8_ling_prefix_lvl #(.K(4)) u_lvl3 (
        .h      (h2_p1),
        .pr     (pr2_p1),
        .h_nxt  (h_lv3),
        .pr_nxt (pr_unused_lv3)
    );

    // Real carry out of bit i is p_i & H_i; it enters bit i+1, wrapping at the top.
    assign carry = rotl(p_p1 & h_lv3, 1);
    assign sum   = x_p1 ^ carry;

    // ---- stage boundary S1 -> S2 -> S3 (data, no reset) ----
    always_ff @(posedge clk) begin
        if (ld_p0 && in_valid) begin
            g_p0 <= a & ~b;
            p_p0 <= a | ~b;
            x_p0 <= a ^ ~b;
        end
        if (ld_p1 && vld_p0) begin
            h2_p1  <= h_lv2;
            pr2_p1 <= pr_lv2;
            p_p1   <= p_p0;
            x_p1   <= x_p0;
        end
    end

    // ---- valid bits and the output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            diff_p2 <= '0;
        end else begin
            if (ld_p0)
                vld_p0 <= in_valid;
            if (ld_p1)
                vld_p1 <= vld_p0;
            if (ld_p2)
                vld_p2 <= vld_p1;
            if (ld_p2 && vld_p1)
                diff_p2 <= norm_zero(sum);
        end
    end

    assign diff      = diff_p2;
    assign out_valid = vld_p2;

endmodule

// File: tb/tb_l8_mod_sub_pipe.sv
// Directed and randomised checks of l8_mod_sub_pipe with NORM_ZERO=1 and NORM_ZERO=0 instances.
module tb_l8_mod_sub_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [7:0] diff;
    logic       in_ready_nz0, out_valid_nz0;
    logic [7:0] diff_nz0;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    l8_mod_sub_pipe #(.NORM_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    l8_mod_sub_pipe #(.NORM_ZERO(1'b0)) dut_nz0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready_nz0),
        .diff      (diff_nz0),
        .out_valid (out_valid_nz0),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] modref(input logic [7:0] x, input logic [7:0] y, input bit nz);
        int xv, yv, d;
        xv = (x == 8'hFF) ? 0 : int'(x);
        yv = (y == 8'hFF) ? 0 : int'(y);
        d  = (xv - yv + 255) % 255;
        if (d == 0)
            return nz ? 8'h00 : 8'hFF;
        return d[7:0];
    endfunction

    // One isolated transaction; checks acceptance, 3-edge latency and both results.
    task automatic run_vec(input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] e1, input logic [7:0] e0);
        int n;
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("vec_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("vec_latency", n, 3);
        chk("vec_diff", diff, e1);
        chk("vec_diff_nz0", diff_nz0, e0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] va, vb, e1, e0;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        acc, seen, sent, got;
        bit        fire;
        logic [15:0] q[$];
        logic [15:0] e;

        tbl[0]  = '{8'h05, 8'h03, 8'h02, 8'h02};
        tbl[1]  = '{8'h03, 8'h05, 8'hFD, 8'hFD};
        tbl[2]  = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        tbl[3]  = '{8'h40, 8'h40, 8'h00, 8'hFF};
        tbl[4]  = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        tbl[5]  = '{8'hFE, 8'h01, 8'hFD, 8'hFD};
        tbl[6]  = '{8'h01, 8'hFE, 8'h02, 8'h02};
        tbl[7]  = '{8'h80, 8'h7F, 8'h01, 8'h01};
        tbl[8]  = '{8'h7F, 8'h80, 8'hFE, 8'hFE};
        tbl[9]  = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
        tbl[10] = '{8'h00, 8'h01, 8'hFE, 8'hFE};
        tbl[11] = '{8'hC8, 8'h64, 8'h64, 8'h64};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in_ready_nz0", in_ready_nz0, 1);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++)
            run_vec(tbl[i].va, tbl[i].vb, tbl[i].e1, tbl[i].e0);

        // Backpressure: offer 1..4 minus 0 with the consumer stalled for 6 cycles.
        out_ready = 1'b0; a = 8'h01; b = 8'h00; in_valid = 1'b1; acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin
                acc++;
                if (acc < 4) a = 8'(acc + 1);
                else         in_valid = 1'b0;
            end
        end
        #1;
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_diff", diff, 8'h01);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("bp_rel_valid", out_valid, 1);
            chk("bp_rel_diff", diff, k);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        @(posedge clk); #1;

        // Reset with two items in flight.
        a = 8'h0A; b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        a = 8'h14; b = 8'h05;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_diff", diff, 8'h00);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", in_ready, 1);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_ghost", seen, 0);
        run_vec(8'hC8, 8'h64, 8'h64, 8'h64);

        // Random stream against the reference model.
        sent = 0; got = 0; in_valid = 1'b0;
        for (int cyc = 0; cyc < 4000 && got < 200; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_diff", diff, e[15:8]);
                    chk("rnd_diff_nz0", diff_nz0, e[7:0]);
                    chk("rnd_valid_nz0", out_valid_nz0, 1);
                    got++;
                end
            end
            fire = in_valid && in_ready;
            if (fire) begin
                q.push_back({modref(a, b, 1'b1), modref(a, b, 1'b0)});
                sent++;
            end
            @(posedge clk); #1;
            if (!in_valid || fire) begin
                if (sent < 200) begin
                    in_valid = 1'($urandom_range(0, 1));
                    a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("rnd_count", got, 200);
        chk("rnd_leftover", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
